// File: rtl/sub_pkg.sv
// Shared types and defaults for the serial chunk subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit ripple subtractor: {bout, diff} = a - b - bin.
module chunk_subtractor
  import sub_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] borrow;

  assign borrow[0] = bin;

  // A bit borrows when b plus the incoming borrow exceeds a.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bout = borrow[CHUNK];

endmodule

// File: rtl/serial_chunk_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one CHUNK slice per cycle, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_chunk_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
    $fatal(1, "serial_chunk_subtractor: WIDTH must be a multiple of CHUNK");
  end

  sub_state_t       state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic [IDX_W-1:0] idx;
  logic             borrow, bout_reg;
  logic [CHUNK-1:0] slice_d;
  logic             slice_bout;
  logic             last;

  assign last = (idx == IDX_W'(NCHUNK - 1));

  // One slice subtractor shared across all slices, selected by idx.
  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_reg[idx*CHUNK +: CHUNK]),
    .b    (b_reg[idx*CHUNK +: CHUNK]),
    .bin  (borrow),
    .diff (slice_d),
    .bout (slice_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
      bout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            idx    <= '0;
          end
        end
        RUN: begin
          diff_reg[idx*CHUNK +: CHUNK] <= slice_d;
          borrow                       <= slice_bout;
          idx                          <= last ? '0 : idx + 1'b1;
          if (last) bout_reg <= slice_bout;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic ovf_reg;

  // Operands of differing sign whose result sign departs from the minuend overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                 (slice_d[CHUNK-1] != a_reg[WIDTH-1]);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_chunk_subtractor.sv
// Randomized and directed bench for serial_chunk_subtractor (WIDTH=16, CHUNK=4).
// Checks ovf only when SUB_OVERFLOW_EN is defined.
module tb_serial_chunk_subtractor;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  int tests    = 0;
  int failures = 0;

  serial_chunk_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction against a plain-arithmetic reference; hold = DONE backpressure cycles.
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic binv, input int hold);
    int               full;
    int               cnt;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
`ifdef SUB_OVERFLOW_EN
    int               sfull;
    logic             exp_ovf;
    sfull   = int'($signed(av)) - int'($signed(bv)) - int'(binv);
    exp_ovf = (sfull > 32767) || (sfull < -32768);
`endif
    full     = int'(av) - int'(bv) - int'(binv);
    exp_diff = full[WIDTH-1:0];
    exp_bout = (full < 0);

    @(negedge clk);
    check_output("idle_in_ready", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    bin      = binv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    bin      = 1'($urandom);
    cnt      = 0;
    while (!out_valid && cnt < NCHUNK + 10) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    check_output("latency", 32'(cnt), 32'(NCHUNK));
    check_output("diff", 32'(diff), 32'(exp_diff));
    check_output("bout", 32'(bout), 32'(exp_bout));
    check_output("done_in_ready", 32'(in_ready), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check_output("ovf", 32'(ovf), 32'(exp_ovf));
`endif

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(negedge clk);
      check_output("hold_out_valid", 32'(out_valid), 32'd1);
      check_output("hold_diff", 32'(diff), 32'(exp_diff));
      check_output("hold_bout", 32'(bout), 32'(exp_bout));
      check_output("hold_in_ready", 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output("release_out_valid", 32'(out_valid), 32'd0);
    check_output("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_diff", 32'(diff), 32'd0);
    check_output("reset_bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check_output("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(16'h1234, 16'h0034, 1'b0, 0);
    apply_stimulus(16'h1000, 16'h0001, 1'b0, 0);
    apply_stimulus(16'h0000, 16'h0001, 1'b0, 0);
    apply_stimulus(16'h0005, 16'h0005, 1'b1, 0);
    apply_stimulus(16'h0000, 16'h0000, 1'b1, 0);
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 5);
    apply_stimulus(16'h8000, 16'h0001, 1'b0, 0);
    apply_stimulus(16'h7FFF, 16'hFFFF, 1'b0, 0);

    // Abort an operation with reset once slice 2 is in flight.
    @(negedge clk);
    a        = 16'hABCD;
    b        = 16'h0123;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrun_out_valid", 32'(out_valid), 32'd0);
    check_output("midrun_in_ready", 32'(in_ready), 32'd1);
    check_output("midrun_diff", 32'(diff), 32'd0);
    check_output("midrun_bout", 32'(bout), 32'd0);
    @(negedge clk);
    check_output("inreset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(16'h00FF, 16'h000F, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
